prio_encoder8_3_latched: RTL and testbench

// Encode direction for the 3-to-8 decoder: collects eight one-hot event/request

---
 rtl/prio_encoder8_3_latched_pkg.sv | 20 ++
 rtl/prio_encoder8_3_latched_if.sv | 23 ++
 rtl/prio_encoder8_3_latched_prio_enc.sv | 29 ++
 rtl/prio_encoder8_3_latched.sv | 83 ++++++++
 tb/tb_prio_encoder8_3_latched.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/prio_encoder8_3_latched_pkg.sv
// Shared widths, FSM state encoding and the one-hot helper for the latched
// priority encoder.
package prio_encoder8_3_latched_pkg;

    localparam int N = 8;
    localparam int W = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    function automatic logic [N-1:0] onehot(input logic [W-1:0] idx);
        logic [N-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/prio_encoder8_3_latched_if.sv
// Request/grant bundle between event sources, the encoder and its consumer.
// master = consumer/stimulus side, slave = encoder side.
interface prio_encoder8_3_latched_if;
    import prio_encoder8_3_latched_pkg::*;

    logic [N-1:0] req;
    logic [N-1:0] mask;
    logic         ack;
    logic         valid;
    logic [W-1:0] code;
    logic [N-1:0] pending;

    modport master (
        output req, mask, ack,
        input  valid, code, pending
    );

    modport slave (
        input  req, mask, ack,
        output valid, code, pending
    );

endinterface

// File: rtl/prio_encoder8_3_latched_prio_enc.sv
// Purpose: combinational 8:3 priority encoder, highest or lowest index wins.
// Latency: zero cycles (pure combinational).
// Backpressure: none; consumer samples idx_o/none_o when it needs them.
module prio_enc8_3
    import prio_encoder8_3_latched_pkg::*;
#(
    parameter bit HI_WINS = 1'b1
) (
    input  logic [N-1:0] sel_i,
    output logic [W-1:0] idx_o,
    output logic         none_o
);

    // The scan direction makes the last hit the winner.
    always_comb begin
        idx_o  = '0;
        none_o = (sel_i == '0);
        if (HI_WINS) begin
            for (int i = 0; i < N; i++) begin
                if (sel_i[i]) idx_o = W'(i);
            end
        end else begin
            for (int i = N - 1; i >= 0; i--) begin
                if (sel_i[i]) idx_o = W'(i);
            end
        end
    end

endmodule

// File: rtl/prio_encoder8_3_latched.sv
// Purpose: sticky pending bits, priority-selected grant code held until ack.
// Latency: req at cycle t -> pending after edge t+1 -> valid after edge t+2.
// Backpressure: code frozen while valid=1 and ack=0; one IDLE bubble per ack.
module prio_encoder8_3_latched
    import prio_encoder8_3_latched_pkg::*;
#(
    parameter bit HI_WINS = 1'b1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    prio_encoder8_3_latched_if.slave       bus
);

    state_e       state_q;
    logic         valid_q;
    logic [W-1:0] code_q;
    logic [N-1:0] pending_q;
    logic [N-1:0] pending_d;
    logic [N-1:0] clr;
    logic [N-1:0] sel;
    logic [W-1:0] prio_idx;
    logic         none;

    assign sel = pending_q & ~bus.mask;

    prio_enc8_3 #(
        .HI_WINS (HI_WINS)
    ) u_enc (
        .sel_i  (sel),
        .idx_o  (prio_idx),
        .none_o (none)
    );

    // A request arriving on the line being cleared keeps it pending.
    always_comb begin
        clr = '0;
        if (valid_q && bus.ack) clr = onehot(code_q);
        pending_d = (pending_q & ~clr) | bus.req;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            code_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!none) begin
                        state_q <= GRANT;
                        valid_q <= 1'b1;
                        code_q  <= prio_idx;
                    end
                end
                GRANT: begin
                    if (bus.ack) begin
                        state_q <= IDLE;
                        valid_q <= 1'b0;
                        code_q  <= '0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                    code_q  <= '0;
                end
            endcase
        end
    end

    assign bus.valid   = valid_q;
    assign bus.code    = code_q;
    assign bus.pending = pending_q;

endmodule

// File: tb/tb_prio_encoder8_3_latched.sv
// Bench for both priority directions driven by identical req/mask/ack streams.
module tb_prio_encoder8_3_latched;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] req = '0;
    logic [7:0] mask = '0;
    logic       ack = 1'b0;
    logic       mon_en = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    prio_encoder8_3_latched_if if_hi ();
    prio_encoder8_3_latched_if if_lo ();

    assign if_hi.req  = req;
    assign if_hi.mask = mask;
    assign if_hi.ack  = ack;
    assign if_lo.req  = req;
    assign if_lo.mask = mask;
    assign if_lo.ack  = ack;

    prio_encoder8_3_latched #(.HI_WINS(1'b1)) dut_hi (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_hi.slave)
    );

    prio_encoder8_3_latched #(.HI_WINS(1'b0)) dut_lo (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_lo.slave)
    );

    logic [1:0]      dv;
    logic [1:0][2:0] dc;
    logic [1:0][7:0] dp;
    assign dv[0] = if_hi.valid;
    assign dv[1] = if_lo.valid;
    assign dc[0] = if_hi.code;
    assign dc[1] = if_lo.code;
    assign dp[0] = if_hi.pending;
    assign dp[1] = if_lo.pending;

    typedef struct packed {
        logic [1:0]      v;
        logic [1:0][2:0] c;
        logic [1:0][7:0] p;
    } snap_t;

    snap_t sq[$];
    int    gq_hi[$];
    int    gq_lo[$];

    // Reference state: index 0 = highest-wins unit, index 1 = lowest-wins unit.
    bit       mv[2];
    bit [2:0] mc[2];
    bit [7:0] mp[2];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Advance the reference by one clock edge using the inputs present at that edge.
    task automatic model_step();
        snap_t s;
        for (int k = 0; k < 2; k++) begin
            bit [7:0] np;
            bit [7:0] elig;
            int       best;
            if (!rst_n) begin
                mp[k] = '0;
                mv[k] = 1'b0;
                mc[k] = '0;
            end else begin
                np = mp[k];
                if (mv[k] && ack) np[mc[k]] = 1'b0;
                np = np | req;
                if (!mv[k]) begin
                    elig = mp[k] & ~mask;
                    best = -1;
                    for (int i = 0; i < 8; i++) begin
                        if (elig[i] && (best < 0 || k == 0)) best = i;
                    end
                    if (best >= 0) begin
                        mv[k] = 1'b1;
                        mc[k] = 3'(best);
                        if (k == 0) gq_hi.push_back(best);
                        else        gq_lo.push_back(best);
                    end
                end else if (ack) begin
                    mv[k] = 1'b0;
                    mc[k] = '0;
                end
                mp[k] = np;
            end
            s.v[k] = mv[k];
            s.c[k] = mc[k];
            s.p[k] = mp[k];
        end
        sq.push_back(s);
    endtask

    task automatic tick(input logic [7:0] r, input logic [7:0] m, input logic a);
        req  = r;
        mask = m;
        ack  = a;
        @(posedge clk);
        #1;
        model_step();
    endtask

    task automatic reset_mid();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid_hi", int'(if_hi.valid), 0);
        chk("async_rst_code_hi", int'(if_hi.code), 0);
        chk("async_rst_pending_hi", int'(if_hi.pending), 0);
        chk("async_rst_valid_lo", int'(if_lo.valid), 0);
        chk("async_rst_pending_lo", int'(if_lo.pending), 0);
        tick(8'hff, 8'h00, 1'b1);
        rst_n = 1'b1;
    endtask

    snap_t    mon_s;
    int       mon_g;
    bit [1:0] pv = '0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (sq.size() > 0) begin
                mon_s = sq.pop_front();
                for (int k = 0; k < 2; k++) begin
                    chk($sformatf("valid[%0d]", k), int'(dv[k]), int'(mon_s.v[k]));
                    chk($sformatf("code[%0d]", k), int'(dc[k]), int'(mon_s.c[k]));
                    chk($sformatf("pending[%0d]", k), int'(dp[k]), int'(mon_s.p[k]));
                end
            end
            for (int k = 0; k < 2; k++) begin
                if (dv[k] && !pv[k]) begin
                    if ((k == 0 && gq_hi.size() == 0) || (k == 1 && gq_lo.size() == 0)) begin
                        checks++;
                        errors++;
                        $display("FAIL grant[%0d]: got unexpected grant code %0d expected none", k, dc[k]);
                    end else begin
                        mon_g = (k == 0) ? gq_hi.pop_front() : gq_lo.pop_front();
                        chk($sformatf("grant[%0d]", k), int'(dc[k]), mon_g);
                    end
                end
            end
            pv <= dv;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #3;
        chk("reset_valid_hi", int'(if_hi.valid), 0);
        chk("reset_code_hi", int'(if_hi.code), 0);
        chk("reset_pending_hi", int'(if_hi.pending), 0);
        chk("reset_valid_lo", int'(if_lo.valid), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // single request, held grant, then ack
        tick(8'h20, 8'h00, 1'b0);
        repeat (6) tick(8'h00, 8'h00, 1'b0);
        tick(8'h00, 8'h00, 1'b1);
        tick(8'h00, 8'h00, 1'b0);

        // two requests, opposite order per direction
        tick(8'h81, 8'h00, 1'b0);
        tick(8'h00, 8'h00, 1'b0);
        tick(8'h00, 8'h00, 1'b1);
        tick(8'h00, 8'h00, 1'b0);
        tick(8'h00, 8'h00, 1'b1);
        tick(8'h00, 8'h00, 1'b0);

        // grant frozen against a later higher-priority request
        tick(8'h04, 8'h00, 1'b0);
        tick(8'h00, 8'h00, 1'b0);
        tick(8'h40, 8'h00, 1'b0);
        tick(8'h00, 8'h00, 1'b0);
        tick(8'h00, 8'h00, 1'b1);
        tick(8'h00, 8'h00, 1'b0);
        tick(8'h00, 8'h00, 1'b1);
        tick(8'h00, 8'h00, 1'b0);

        // re-request on the line being acknowledged
        tick(8'h08, 8'h00, 1'b0);
        tick(8'h00, 8'h00, 1'b0);
        tick(8'h08, 8'h00, 1'b1);
        tick(8'h00, 8'h00, 1'b0);
        tick(8'h00, 8'h00, 1'b1);
        tick(8'h00, 8'h00, 1'b0);

        // masked pending line, ack while idle, then unmask
        tick(8'h10, 8'h10, 1'b0);
        tick(8'h00, 8'h10, 1'b0);
        tick(8'h00, 8'h10, 1'b0);
        tick(8'h00, 8'h10, 1'b1);
        tick(8'h00, 8'h00, 1'b0);
        tick(8'h00, 8'h00, 1'b1);
        tick(8'h00, 8'h00, 1'b0);

        // asynchronous reset in the middle of a grant
        tick(8'h20, 8'h00, 1'b0);
        tick(8'h00, 8'h00, 1'b0);
        reset_mid();
        tick(8'h00, 8'h00, 1'b0);
        tick(8'h00, 8'h00, 1'b0);

        for (int n = 0; n < 500; n++) begin
            tick(8'($urandom & $urandom & $urandom),
                 (n % 100 < 20) ? 8'h00 : 8'($urandom & $urandom),
                 1'($urandom_range(0, 2) == 0));
        end

        repeat (20) tick(8'h00, 8'h00, 1'b1);
        @(negedge clk);
        #1;
        chk("state_queue_drained", sq.size(), 0);
        chk("grant_queue_hi_drained", gq_hi.size(), 0);
        chk("grant_queue_lo_drained", gq_lo.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
